// File: rtl/operand_fetch_unit.sv
// ModR/M operand front end: pulls disp/imm from the prefetch queue, forms EA and segment, moves the operand over the BCU.
// Latency: register operand 2 ce cycles start->operand_valid; word read 4 ce cycles plus BCU wait; dword adds one more transfer.
// Backpressure: FETCH stalls until the queue holds disp+imm bytes; every transfer waits for dp_ready before issue and completion.
module operand_fetch_unit #(
    parameter int IPQ_DEPTH = 8,
    parameter int MAX_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           ce,
    input  logic                           start,
    input  logic [1:0]                     mod,
    input  logic [2:0]                     rm,
    input  logic [1:0]                     width,
    input  logic [1:0]                     imm_size,
    input  logic                           mem_read,
    input  logic                           seg_ovr_valid,
    input  logic [1:0]                     seg_ovr,
    input  logic [15:0]                    reg_bw,
    input  logic [15:0]                    reg_bp,
    input  logic [15:0]                    reg_ix,
    input  logic [15:0]                    reg_iy,
    input  logic [8*IPQ_DEPTH-1:0]         ipq_data,
    input  logic [$clog2(IPQ_DEPTH)-1:0]   ipq_head,
    input  logic [$clog2(IPQ_DEPTH):0]     ipq_len,
    output logic                           ipq_consume,
    output logic [2:0]                     ipq_consume_n,
    output logic [15:0]                    dp_addr,
    output logic [1:0]                     dp_sreg,
    output logic                           dp_wide,
    output logic                           dp_write,
    output logic [15:0]                    dp_dout,
    output logic                           dp_req,
    input  logic                           dp_ready,
    input  logic [15:0]                    dp_din,
    input  logic                           store,
    input  logic [31:0]                    store_data,
    // "release" is a reserved word, hence the prefix
    input  logic                           op_release,
    output logic [15:0]                    ea,
    output logic [15:0]                    imm,
    output logic [31:0]                    operand,
    output logic                           operand_valid,
    output logic                           busy,
    output logic                           illegal
);

    localparam int AW = $clog2(IPQ_DEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, RD_LO, RD_HI, HOLD, WR_LO, WR_HI} state_t;
    // ISSUE: waiting to toggle; SKIP: cycle after toggle, dp_ready ignored; WAIT: completion on dp_ready
    typedef enum logic [1:0] {PH_ISSUE, PH_SKIP, PH_WAIT} phase_t;

    state_t      state;
    phase_t      phase;
    logic [1:0]  c_mod, c_width, c_imm_size, c_ovr, seg_q;
    logic [2:0]  c_rm;
    logic        c_mem_read, c_ovr_vld;
    logic [15:0] lo_q;
    logic [31:0] st_q;

    logic [2:0]  disp_n, need;
    logic [7:0]  b_d0, b_d1, b_i0, b_i1;
    logic [15:0] disp_val, base, ea_calc, imm_calc, l_addr, l_dout;
    logic [1:0]  seg_calc, l_seg;
    logic        fetch_ok, mem_op, xfer_state, launch, done, hi_sel, l_write, l_wide, bad_width;

    function automatic logic [7:0] ipq_byte(input logic [8*IPQ_DEPTH-1:0] q, input logic [AW-1:0] idx);
        return q[8*idx +: 8];
    endfunction

    // Decode of the captured ModR/M: byte counts, displacement, EA, segment and the next bus transfer
    always_comb begin
        disp_n = 3'd0;
        case (c_mod)
            2'b00:   disp_n = (c_rm == 3'b110) ? 3'd2 : 3'd0;
            2'b01:   disp_n = 3'd1;
            2'b10:   disp_n = 3'd2;
            default: disp_n = 3'd0;
        endcase
        need = disp_n + {1'b0, c_imm_size};
        b_d0 = ipq_byte(ipq_data, ipq_head);
        b_d1 = ipq_byte(ipq_data, ipq_head + AW'(3'd1));
        b_i0 = ipq_byte(ipq_data, ipq_head + AW'(disp_n));
        b_i1 = ipq_byte(ipq_data, ipq_head + AW'(disp_n + 3'd1));

        if (c_mod == 2'b01)       disp_val = {{8{b_d0[7]}}, b_d0};
        else if (disp_n == 3'd2)  disp_val = {b_d1, b_d0};
        else                      disp_val = 16'h0000;

        base = 16'h0000;
        case (c_rm)
            3'b000:  base = reg_bw + reg_ix;
            3'b001:  base = reg_bw + reg_iy;
            3'b010:  base = reg_bp + reg_ix;
            3'b011:  base = reg_bp + reg_iy;
            3'b100:  base = reg_ix;
            3'b101:  base = reg_iy;
            3'b110:  base = (c_mod == 2'b00) ? 16'h0000 : reg_bp;
            default: base = reg_bw;
        endcase
        ea_calc = base + disp_val;

        if (c_ovr_vld)
            seg_calc = c_ovr;
        else if (c_rm == 3'b010 || c_rm == 3'b011 || (c_rm == 3'b110 && c_mod != 2'b00))
            seg_calc = 2'd2;
        else
            seg_calc = 2'd3;

        if (c_imm_size == 2'd0)       imm_calc = 16'h0000;
        else if (c_imm_size == 2'd1)  imm_calc = {8'h00, b_i0};
        else                          imm_calc = {b_i1, b_i0};

        fetch_ok   = 32'(ipq_len) >= 32'(need);
        mem_op     = (c_mod != 2'b11) && c_mem_read;
        xfer_state = (state == RD_LO) || (state == RD_HI) || (state == WR_LO) || (state == WR_HI);
        done       = xfer_state && (phase == PH_WAIT) && dp_ready;
        // A low-half state past its issue phase can only launch the high half
        hi_sel     = (state == RD_HI) || (state == WR_HI) ||
                     (((state == RD_LO) || (state == WR_LO)) && (phase != PH_ISSUE));
        launch     = dp_ready && (
                        ((state == FETCH) && fetch_ok && mem_op) ||
                        (xfer_state && (phase == PH_ISSUE)) ||
                        (((state == RD_LO) || (state == WR_LO)) && (phase == PH_WAIT) && (c_width == 2'd2)) ||
                        ((state == HOLD) && store && (c_mod != 2'b11)));
        l_write    = (state == HOLD) || (state == WR_LO) || (state == WR_HI);
        l_wide     = (c_width != 2'd0);
        l_seg      = (state == FETCH) ? seg_calc : seg_q;
        if (hi_sel)               l_addr = ea + 16'd2;
        else if (state == FETCH)  l_addr = ea_calc;
        else                      l_addr = ea;
        if (!l_write)             l_dout = 16'h0000;
        else if (state == HOLD)   l_dout = store_data[15:0];
        else if (hi_sel)          l_dout = st_q[31:16];
        else                      l_dout = st_q[15:0];

        bad_width = (width == 2'd3) || ((width == 2'd2) && (MAX_WIDTH < 2));
    end

    // Operand sequencer: capture, fetch, read(s), hold, write(s); all outputs registered
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= IDLE;          phase <= PH_ISSUE;
            dp_req <= 1'b0;         dp_write <= 1'b0;       dp_wide <= 1'b0;
            dp_addr <= 16'h0000;    dp_dout <= 16'h0000;    dp_sreg <= 2'd3;
            ipq_consume <= 1'b0;    ipq_consume_n <= 3'd0;
            ea <= 16'h0000;         imm <= 16'h0000;        operand <= 32'h0;
            operand_valid <= 1'b0;  busy <= 1'b0;           illegal <= 1'b0;
            c_mod <= 2'd0;          c_rm <= 3'd0;           c_width <= 2'd0;
            c_imm_size <= 2'd0;     c_mem_read <= 1'b0;     c_ovr_vld <= 1'b0;
            c_ovr <= 2'd0;          seg_q <= 2'd3;          lo_q <= 16'h0000;
            st_q <= 32'h0;
        end else if (ce) begin
            ipq_consume <= 1'b0;
            illegal     <= 1'b0;
            if (launch) begin
                dp_req   <= ~dp_req;
                dp_addr  <= l_addr;
                dp_sreg  <= l_seg;
                dp_wide  <= l_wide;
                dp_write <= l_write;
                dp_dout  <= l_dout;
                phase    <= PH_SKIP;
            end
            case (state)
                IDLE: if (start) begin
                    if (bad_width) begin
                        illegal <= 1'b1;
                    end else begin
                        c_mod <= mod;           c_rm <= rm;             c_width <= width;
                        c_imm_size <= imm_size; c_mem_read <= mem_read;
                        c_ovr_vld <= seg_ovr_valid;                     c_ovr <= seg_ovr;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: if (fetch_ok) begin
                    ipq_consume   <= 1'b1;
                    ipq_consume_n <= need;
                    ea    <= ea_calc;
                    imm   <= imm_calc;
                    seg_q <= seg_calc;
                    if (mem_op) begin
                        state <= RD_LO;
                        if (!dp_ready) phase <= PH_ISSUE;
                    end else begin
                        state         <= HOLD;
                        operand       <= 32'h0;
                        operand_valid <= 1'b1;
                    end
                end
                RD_LO, RD_HI, WR_LO, WR_HI: begin
                    if (phase == PH_SKIP) begin
                        phase <= PH_WAIT;
                    end else if (done) begin
                        if (state == RD_LO) begin
                            if (c_width == 2'd2) begin
                                lo_q  <= dp_din;
                                state <= RD_HI;
                            end else begin
                                operand       <= (c_width == 2'd0) ? {24'h0, dp_din[7:0]} : {16'h0, dp_din};
                                operand_valid <= 1'b1;
                                state         <= HOLD;
                            end
                        end else if (state == RD_HI) begin
                            operand       <= {dp_din, lo_q};
                            operand_valid <= 1'b1;
                            state         <= HOLD;
                        end else if (state == WR_LO && c_width == 2'd2) begin
                            state <= WR_HI;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (store && c_mod != 2'b11) begin
                        st_q          <= store_data;
                        operand_valid <= 1'b0;
                        state         <= WR_LO;
                        if (!dp_ready) phase <= PH_ISSUE;
                    end else if (store || op_release) begin
                        operand_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit with a BCU responder and expected-value queues.
// Latency: n/a.
// Backpressure: the BCU responder stalls dp_ready for a programmable number of cycles per transfer.
module tb_operand_fetch_unit;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_reset, ce, start, mem_read, seg_ovr_valid, dp_ready, store, op_release;
    logic [1:0] mod, width, imm_size, seg_ovr;
    logic [2:0] rm;
    logic [15:0] reg_bw, reg_bp, reg_ix, reg_iy, dp_din;
    logic [8*D-1:0] ipq_data;
    logic [2:0] ipq_head;
    logic [3:0] ipq_len;
    logic [31:0] store_data;
    logic ipq_consume, dp_wide, dp_write, dp_req, operand_valid, busy, illegal;
    logic [2:0] ipq_consume_n;
    logic [15:0] dp_addr, dp_dout, ea, imm;
    logic [1:0] dp_sreg;
    logic [31:0] operand;

    operand_fetch_unit #(.IPQ_DEPTH(D), .MAX_WIDTH(2)) dut (
        .clk(clk), .n_reset(n_reset), .ce(ce), .start(start), .mod(mod), .rm(rm), .width(width),
        .imm_size(imm_size), .mem_read(mem_read), .seg_ovr_valid(seg_ovr_valid), .seg_ovr(seg_ovr),
        .reg_bw(reg_bw), .reg_bp(reg_bp), .reg_ix(reg_ix), .reg_iy(reg_iy),
        .ipq_data(ipq_data), .ipq_head(ipq_head), .ipq_len(ipq_len),
        .ipq_consume(ipq_consume), .ipq_consume_n(ipq_consume_n),
        .dp_addr(dp_addr), .dp_sreg(dp_sreg), .dp_wide(dp_wide), .dp_write(dp_write), .dp_dout(dp_dout),
        .dp_req(dp_req), .dp_ready(dp_ready), .dp_din(dp_din),
        .store(store), .store_data(store_data), .op_release(op_release),
        .ea(ea), .imm(imm), .operand(operand), .operand_valid(operand_valid), .busy(busy), .illegal(illegal)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  sreg;
        logic        wide;
        logic        write;
        logic [15:0] dout;
    } bus_t;

    typedef struct packed {
        logic [15:0] ea;
        logic [15:0] imm;
        logic [31:0] operand;
    } res_t;

    bus_t exp_bus[$];
    res_t exp_res[$];
    int total = 0;
    int bad = 0;
    int toggles = 0;
    int cons_cnt = 0;
    int wait_left = 0;
    int bcu_wait = 0;
    logic [2:0] cons_n = 3'd0;
    logic last_req = 1'b0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    function automatic bus_t mk_bus(input logic [15:0] a, input logic [1:0] s, input logic w,
                                    input logic wr, input logic [15:0] d);
        bus_t b;
        b.addr = a; b.sreg = s; b.wide = w; b.write = wr; b.dout = d;
        return b;
    endfunction

    function automatic res_t mk_res(input logic [15:0] e, input logic [15:0] i, input logic [31:0] o);
        res_t r;
        r.ea = e; r.imm = i; r.operand = o;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards play the BCU: log consume pulses, check each request toggle, pace dp_ready
    task automatic tick();
        bus_t ob, ex;
        @(posedge clk);
        #1;
        if (ipq_consume === 1'b1) begin
            cons_cnt++;
            cons_n = ipq_consume_n;
        end
        if (n_reset === 1'b1 && dp_req !== last_req) begin
            last_req = dp_req;
            toggles++;
            ob.addr = dp_addr; ob.sreg = dp_sreg; ob.wide = dp_wide; ob.write = dp_write; ob.dout = dp_dout;
            if (exp_bus.size() > 0) ex = exp_bus.pop_front();
            else ex = '1;
            check("bus_xfer", 64'(ob), 64'(ex));
            dp_din = mem_rd(dp_addr);
            if (bcu_wait == 0) begin
                dp_ready = 1'b1;
            end else begin
                dp_ready  = 1'b0;
                wait_left = bcu_wait;
            end
        end else if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) dp_ready = 1'b1;
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic [2:0] r, input logic [1:0] w,
                            input logic [1:0] isz, input logic mr, input logic ovv, input logic [1:0] ov);
        mod = m; rm = r; width = w; imm_size = isz; mem_read = mr; seg_ovr_valid = ovv; seg_ovr = ov;
        start = 1'b1;
        tick();
        start = 1'b0;
        mod = 2'd0; rm = 3'd0;
    endtask

    // Waits (bounded) for operand_valid; n counts ce cycles from the start cycle
    task automatic wait_valid(input string tag, output int n);
        n = 1;
        for (int i = 0; i < 60 && operand_valid !== 1'b1; i++) begin
            tick();
            n++;
        end
        check(tag, 64'(operand_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic do_ea);
        res_t ex;
        if (exp_res.size() > 0) ex = exp_res.pop_front();
        else ex = '1;
        if (do_ea) check({tag, "_ea"}, 64'(ea), 64'(ex.ea));
        check({tag, "_imm"}, 64'(imm), 64'(ex.imm));
        check({tag, "_operand"}, 64'(operand), 64'(ex.operand));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dp"}, 64'({dp_req, dp_write, dp_wide, dp_sreg, dp_addr, dp_dout}),
              64'({3'b000, 2'd3, 32'h0}));
        check({tag, "_ctl"}, 64'({ipq_consume, operand_valid, busy, illegal, ea, imm}), 64'd0);
        check({tag, "_operand"}, 64'(operand), 64'd0);
    endtask

    initial begin
        int lat, t0, c0;
        logic [15:0] tmp;
        n_reset = 1'b0; ce = 1'b1; start = 1'b0; mod = 2'd0; rm = 3'd0; width = 2'd0; imm_size = 2'd0;
        mem_read = 1'b0; seg_ovr_valid = 1'b0; seg_ovr = 2'd0; reg_bw = 16'h0; reg_bp = 16'h0;
        reg_ix = 16'h0; reg_iy = 16'h0; ipq_data = '0; ipq_head = 3'd0; ipq_len = 4'd0;
        dp_ready = 1'b1; dp_din = 16'h0; store = 1'b0; store_data = 32'h0; op_release = 1'b0;
        tick();
        tick();
        check_reset("reset");
        n_reset = 1'b1;
        tick();

        // 1: disp8 sign extension, BP+IX, SS default, word read with no BCU wait
        reg_bp = 16'h1000; reg_ix = 16'h0004;
        ipq_data = '0; ipq_data[7:0] = 8'hFE; ipq_head = 3'd0; ipq_len = 4'd8; bcu_wait = 0;
        exp_bus.push_back(mk_bus(16'h1002, 2'd2, 1'b1, 1'b0, 16'h0));
        exp_res.push_back(mk_res(16'h1002, 16'h0, {16'h0, mem_rd(16'h1002)}));
        t0 = toggles; c0 = cons_cnt;
        start_op(2'b01, 3'b010, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0);
        wait_valid("t1_valid", lat);
        check_result("t1", 1'b1);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_consumes", 64'(cons_cnt - c0), 64'd1);
        check("t1_consume_n", 64'(cons_n), 64'd1);
        check("t1_toggles", 64'(toggles - t0), 64'd1);
        op_release = 1'b1;
        tick();
        op_release = 1'b0;
        check("t1_release", 64'({busy, operand_valid}), 64'd0);

        // 2: disp16 + imm16 wrapping the queue end, DS1 override, byte read, store beats release
        ipq_data = '0;
        ipq_data[8*6 +: 8] = 8'h34; ipq_data[8*7 +: 8] = 8'h12;
        ipq_data[8*0 +: 8] = 8'hEF; ipq_data[8*1 +: 8] = 8'hBE;
        ipq_head = 3'd6; ipq_len = 4'd4;
        tmp = mem_rd(16'h1234);
        exp_bus.push_back(mk_bus(16'h1234, 2'd0, 1'b0, 1'b0, 16'h0));
        exp_res.push_back(mk_res(16'h1234, 16'hBEEF, {24'h0, tmp[7:0]}));
        t0 = toggles; c0 = cons_cnt;
        start_op(2'b00, 3'b110, 2'd0, 2'd2, 1'b1, 1'b1, 2'd0);
        wait_valid("t2_valid", lat);
        check_result("t2", 1'b1);
        check("t2_consume_n", 64'(cons_n), 64'd4);
        exp_bus.push_back(mk_bus(16'h1234, 2'd0, 1'b0, 1'b1, 16'h00AB));
        store_data = 32'h0000_00AB; store = 1'b1; op_release = 1'b1;
        tick();
        store = 1'b0; op_release = 1'b0;
        wait_idle("t2_idle");
        check("t2_toggles", 64'(toggles - t0), 64'd2);
        check("t2_valid_off", 64'(operand_valid), 64'd0);

        // 3: queue short of disp16+imm8 for five cycles, then enough; no memory access
        reg_bw = 16'h2000;
        ipq_data = '0; ipq_data[7:0] = 8'h10; ipq_data[15:8] = 8'h00; ipq_data[23:16] = 8'h7F;
        ipq_head = 3'd0; ipq_len = 4'd2;
        exp_res.push_back(mk_res(16'h2010, 16'h007F, 32'h0));
        t0 = toggles; c0 = cons_cnt;
        start_op(2'b10, 3'b111, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0);
        repeat (5) tick();
        check("t3_stall_consume", 64'(cons_cnt - c0), 64'd0);
        check("t3_stall_valid", 64'(operand_valid), 64'd0);
        ipq_len = 4'd3;
        wait_valid("t3_valid", lat);
        check_result("t3", 1'b1);
        check("t3_consumes", 64'(cons_cnt - c0), 64'd1);
        check("t3_consume_n", 64'(cons_n), 64'd3);
        check("t3_toggles", 64'(toggles - t0), 64'd0);
        op_release = 1'b1;
        tick();
        op_release = 1'b0;
        check("t3_release", 64'(busy), 64'd0);

        // 4: dword at 0xFFFE wraps to 0x0000 for both read and write, BCU wait of 2
        reg_ix = 16'hFFFE; ipq_len = 4'd8; bcu_wait = 2;
        exp_bus.push_back(mk_bus(16'hFFFE, 2'd3, 1'b1, 1'b0, 16'h0));
        exp_bus.push_back(mk_bus(16'h0000, 2'd3, 1'b1, 1'b0, 16'h0));
        exp_res.push_back(mk_res(16'hFFFE, 16'h0, {mem_rd(16'h0000), mem_rd(16'hFFFE)}));
        t0 = toggles;
        start_op(2'b00, 3'b100, 2'd2, 2'd0, 1'b1, 1'b0, 2'd0);
        wait_valid("t4_valid", lat);
        check_result("t4", 1'b1);
        check("t4_read_toggles", 64'(toggles - t0), 64'd2);
        exp_bus.push_back(mk_bus(16'hFFFE, 2'd3, 1'b1, 1'b1, 16'hF00D));
        exp_bus.push_back(mk_bus(16'h0000, 2'd3, 1'b1, 1'b1, 16'hCAFE));
        store_data = 32'hCAFE_F00D; store = 1'b1;
        tick();
        store = 1'b0;
        wait_idle("t4_idle");
        check("t4_all_toggles", 64'(toggles - t0), 64'd4);

        // 5: register operand, start while busy ignored, store on mod=11 ends without a write; ce hold
        bcu_wait = 0;
        exp_res.push_back(mk_res(16'h0, 16'h0, 32'h0));
        t0 = toggles; c0 = cons_cnt;
        start_op(2'b11, 3'b000, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0);
        wait_valid("t5_valid", lat);
        check_result("t5", 1'b0);
        check("t5_latency", 64'(lat), 64'd2);
        start_op(2'b01, 3'b010, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0);
        check("t5_busy_start", 64'({operand_valid, busy}), 64'd3);
        check("t5_busy_consume", 64'(cons_cnt - c0), 64'd1);
        store = 1'b1;
        tick();
        store = 1'b0;
        check("t5_store_reg", 64'({operand_valid, busy}), 64'd0);
        check("t5_toggles", 64'(toggles - t0), 64'd0);
        start_op(2'b11, 3'b001, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0);
        ce = 1'b0;
        repeat (3) tick();
        check("t5_ce_hold", 64'(operand_valid), 64'd0);
        ce = 1'b1;
        tick();
        check("t5_ce_resume", 64'(operand_valid), 64'd1);
        op_release = 1'b1;
        tick();
        op_release = 1'b0;

        // 6: reset while the high half of a dword read is outstanding
        reg_bp = 16'h0100; reg_iy = 16'h0002; bcu_wait = 3;
        ipq_data = '0; ipq_data[7:0] = 8'h04; ipq_head = 3'd0;
        exp_bus.push_back(mk_bus(16'h0106, 2'd2, 1'b1, 1'b0, 16'h0));
        exp_bus.push_back(mk_bus(16'h0108, 2'd2, 1'b1, 1'b0, 16'h0));
        t0 = toggles;
        start_op(2'b01, 3'b011, 2'd2, 2'd0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 60 && (toggles - t0) < 2; i++) tick();
        check("t6_hi_issued", 64'(toggles - t0), 64'd2);
        n_reset = 1'b0;
        tick();
        check_reset("t6_reset");
        n_reset = 1'b1; last_req = 1'b0; wait_left = 0; dp_ready = 1'b1;
        t0 = toggles;
        repeat (8) tick();
        check("t6_quiet", 64'({toggles - t0}), 64'd0);
        check("t6_req_low", 64'({dp_req, busy}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
